// File: rtl/exe_ctrl_pkg.sv
// Shared types for the EXE-stage hazard/forwarding controller.
//   ex_slot_t  : register-index shadow of the instruction sitting in EX
//   mem_slot_t : destination info of the instruction sitting in MEM
//   wb_slot_t  : destination info of the instruction sitting in WB
//   state_t    : sequencing state (RUN / FREEZE)
//   REG_ZERO   : index of the hard-wired zero register
// Slot valid bits are kept outside the structs so they can be reset
// independently of the index fields.
package exe_ctrl_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic {
    RUN    = 1'b0,
    FREEZE = 1'b1
  } state_t;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rs;
    logic       uses_rt;
    logic [4:0] dst;
    logic       regwrite;
    logic       memread;
  } ex_slot_t;

  typedef struct packed {
    logic [4:0] dst;
    logic       regwrite;
    logic       memread;
  } mem_slot_t;

  // The WB copy of memread has no consumer: a load that has reached WB
  // forwards exactly like an ALU result.
  typedef struct packed {
    logic [4:0] dst;
    logic       regwrite;
  } wb_slot_t;

endpackage

// File: rtl/fwd_compare.sv
// Forwarding comparator for one EX source operand.
// Ports:
//   src_en        : EX slot valid and the operand is actually read
//   src_idx       : register index of the operand
//   mem_vld/mem_* : MEM slot valid, destination, regwrite, memread
//   wb_vld/wb_*   : WB slot valid, destination, regwrite
//   mem_fwd       : take the MEM-stage ALU result
//   wb_fwd        : take the WB-stage value (only when MEM does not match)
module fwd_compare (
  input  logic       src_en,
  input  logic [4:0] src_idx,
  input  logic       mem_vld,
  input  logic [4:0] mem_dst,
  input  logic       mem_regwrite,
  input  logic       mem_memread,
  input  logic       wb_vld,
  input  logic [4:0] wb_dst,
  input  logic       wb_regwrite,
  output logic       mem_fwd,
  output logic       wb_fwd
);

  // A load in MEM has no result yet; the load-use stall keeps its
  // consumer out of EX until the load reaches WB.
  assign mem_fwd = src_en & mem_vld & mem_regwrite & ~mem_memread &
                   (mem_dst == src_idx);

  // MEM wins over WB so the youngest producer supplies the value.
  assign wb_fwd  = src_en & wb_vld & wb_regwrite & (wb_dst == src_idx) &
                   ~mem_fwd;

endmodule

// File: rtl/exe_hazard_ctrl.sv
// EXE-stage sequencing and forwarding controller for the 5-stage MIPS
// pipeline. Shadows the register indices of the EX, MEM and WB slots and
// derives forwarding selects, load-use stall control and memory freeze.
// Ports:
//   clk, reset                     : clock, synchronous active-high reset
//   id_valid, id_rs/rt/rd          : instruction present in ID and its fields
//   id_uses_rs/rt, id_regdst       : operand usage, destination select
//   id_regwrite, id_memread        : writes a register / is a load
//   flush                          : squash the instruction entering EX
//   mem_busy                       : data memory stall, freeze everything
//   memAdelant_rs/rt, wbAdelant_rs/rt : forwarding selects for EX operands
//   ALU_enable                     : EX slot holds a valid instruction
//   pc_hold, ifid_hold, idex_bubble : front-end stall controls
//   stall_count                    : saturating count of load-use stalls
module exe_hazard_ctrl
  import exe_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_rd,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_regdst,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             flush,
  input  logic             mem_busy,
  output logic             memAdelant_rs,
  output logic             memAdelant_rt,
  output logic             wbAdelant_rs,
  output logic             wbAdelant_rt,
  output logic             ALU_enable,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             idex_bubble,
  output logic [CNT_W-1:0] stall_count
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t     state_q, state_d;
  logic       vld_p0, vld_p1, vld_p2;
  ex_slot_t   ex_p0;
  mem_slot_t  mem_p1;
  wb_slot_t   wb_p2;

  logic       advance;
  logic       stall_inc;
  logic       hz;
  logic [4:0] id_dst;
  logic       id_wr;

  // ID decode into slot form
  assign id_dst = id_regdst ? id_rd : id_rt;
  // Writes to $0 are dropped here so $0 can never become a forwarding source.
  assign id_wr  = id_regwrite & (id_dst != REG_ZERO);

  assign hz = id_valid & vld_p0 & ex_p0.memread & ex_p0.regwrite &
              ((id_uses_rs & (id_rs == ex_p0.dst)) |
               (id_uses_rt & (id_rt == ex_p0.dst)));

  // Sequencing: mem_busy outranks flush, flush outranks the hazard.
  always_comb begin
    state_d     = state_q;
    advance     = 1'b0;
    stall_inc   = 1'b0;
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    idex_bubble = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_busy) begin
          state_d   = FREEZE;
          pc_hold   = 1'b1;
          ifid_hold = 1'b1;
        end else begin
          advance = 1'b1;
          if (hz && !flush) begin
            pc_hold     = 1'b1;
            ifid_hold   = 1'b1;
            idex_bubble = 1'b1;
            stall_inc   = 1'b1;
          end
        end
      end
      FREEZE: begin
        pc_hold   = 1'b1;
        ifid_hold = 1'b1;
        if (!mem_busy) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Control registers: state, slot valids, stall counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      vld_p0      <= 1'b0;
      vld_p1      <= 1'b0;
      vld_p2      <= 1'b0;
      stall_count <= '0;
    end else begin
      state_q <= state_d;
      if (stall_inc) begin
        stall_count <= sat_inc(stall_count);
      end
      if (advance) begin
        vld_p0 <= id_valid & ~flush & ~hz;
        vld_p1 <= vld_p0;
        vld_p2 <= vld_p1;
      end
    end
  end

  // Slot index fields; meaningless while the matching valid is low
  always_ff @(posedge clk) begin
    if (advance) begin
      ex_p0.rs       <= id_rs;
      ex_p0.rt       <= id_rt;
      ex_p0.uses_rs  <= id_uses_rs;
      ex_p0.uses_rt  <= id_uses_rt;
      ex_p0.dst      <= id_dst;
      ex_p0.regwrite <= id_wr;
      ex_p0.memread  <= id_memread;
      mem_p1.dst      <= ex_p0.dst;
      mem_p1.regwrite <= ex_p0.regwrite;
      mem_p1.memread  <= ex_p0.memread;
      wb_p2.dst      <= mem_p1.dst;
      wb_p2.regwrite <= mem_p1.regwrite;
    end
  end

  // EX operand forwarding, evaluated from the current slots
  fwd_compare u_fwd_rs (
    .src_en       (vld_p0 & ex_p0.uses_rs),
    .src_idx      (ex_p0.rs),
    .mem_vld      (vld_p1),
    .mem_dst      (mem_p1.dst),
    .mem_regwrite (mem_p1.regwrite),
    .mem_memread  (mem_p1.memread),
    .wb_vld       (vld_p2),
    .wb_dst       (wb_p2.dst),
    .wb_regwrite  (wb_p2.regwrite),
    .mem_fwd      (memAdelant_rs),
    .wb_fwd       (wbAdelant_rs)
  );

  fwd_compare u_fwd_rt (
    .src_en       (vld_p0 & ex_p0.uses_rt),
    .src_idx      (ex_p0.rt),
    .mem_vld      (vld_p1),
    .mem_dst      (mem_p1.dst),
    .mem_regwrite (mem_p1.regwrite),
    .mem_memread  (mem_p1.memread),
    .wb_vld       (vld_p2),
    .wb_dst       (wb_p2.dst),
    .wb_regwrite  (wb_p2.regwrite),
    .mem_fwd      (memAdelant_rt),
    .wb_fwd       (wbAdelant_rt)
  );

  assign ALU_enable = vld_p0;

endmodule

// File: tb/tb_exe_hazard_ctrl.sv
// Scoreboard bench for exe_hazard_ctrl. The stimulus process drives one ID
// instruction per cycle and pushes the hand-derived expected output word for
// that cycle; the monitor compares on the falling edge.
// A narrow counter width is used so saturation is reachable quickly.
module tb_exe_hazard_ctrl;

  localparam int CNT_W = 2;

  // Expected-flag bit positions:
  // {memAdelant_rs, memAdelant_rt, wbAdelant_rs, wbAdelant_rt,
  //  ALU_enable, pc_hold, ifid_hold, idex_bubble}
  localparam logic [7:0] F_MRS   = 8'h80;
  localparam logic [7:0] F_MRT   = 8'h40;
  localparam logic [7:0] F_WRS   = 8'h20;
  localparam logic [7:0] F_WRT   = 8'h10;
  localparam logic [7:0] F_ALU   = 8'h08;
  localparam logic [7:0] F_HOLD  = 8'h06;
  localparam logic [7:0] F_STALL = 8'h07;

  logic clk = 1'b0;
  logic reset;
  logic id_valid;
  logic [4:0] id_rs, id_rt, id_rd;
  logic id_uses_rs, id_uses_rt, id_regdst, id_regwrite, id_memread;
  logic flush, mem_busy;
  logic memAdelant_rs, memAdelant_rt, wbAdelant_rs, wbAdelant_rt;
  logic ALU_enable, pc_hold, ifid_hold, idex_bubble;
  logic [CNT_W-1:0] stall_count;

  exe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .id_valid      (id_valid),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_rd         (id_rd),
    .id_uses_rs    (id_uses_rs),
    .id_uses_rt    (id_uses_rt),
    .id_regdst     (id_regdst),
    .id_regwrite   (id_regwrite),
    .id_memread    (id_memread),
    .flush         (flush),
    .mem_busy      (mem_busy),
    .memAdelant_rs (memAdelant_rs),
    .memAdelant_rt (memAdelant_rt),
    .wbAdelant_rs  (wbAdelant_rs),
    .wbAdelant_rt  (wbAdelant_rt),
    .ALU_enable    (ALU_enable),
    .pc_hold       (pc_hold),
    .ifid_hold     (ifid_hold),
    .idex_bubble   (idex_bubble),
    .stall_count   (stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               cyc;
    string            name;
    logic [7:0]       flags;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   cyc_cnt = 0;
  int   n_cmp   = 0;
  int   n_bad   = 0;
  bit   done    = 1'b0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Monitor: compare the entry scheduled for the current cycle.
  always @(negedge clk) begin
    logic [7:0] got;
    exp_t       e;
    if (!done) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc_cnt) begin
        e = exp_q.pop_front();
        n_cmp++;
        n_bad++;
        $display("FAIL %s: no sample taken (cycle %0d), required flags=%b cnt=%0d",
                 e.name, e.cyc, e.flags, e.cnt);
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc_cnt) begin
        e   = exp_q.pop_front();
        got = {memAdelant_rs, memAdelant_rt, wbAdelant_rs, wbAdelant_rt,
               ALU_enable, pc_hold, ifid_hold, idex_bubble};
        n_cmp++;
        if (got !== e.flags || stall_count !== e.cnt) begin
          n_bad++;
          $display("FAIL %s: got flags=%b cnt=%0d, required flags=%b cnt=%0d",
                   e.name, got, stall_count, e.flags, e.cnt);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] flags,
                     input logic [CNT_W-1:0] cnt);
    exp_t e;
    e.cyc   = cyc_cnt;
    e.name  = name;
    e.flags = flags;
    e.cnt   = cnt;
    exp_q.push_back(e);
  endtask

  task automatic nop_id();
    id_valid = 1'b0; id_rs = 5'd0; id_rt = 5'd0; id_rd = 5'd0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_regdst = 1'b0;
    id_regwrite = 1'b0; id_memread = 1'b0;
  endtask

  // R-type: rd <- rs op rt
  task automatic alu_r(input logic [4:0] rd, input logic [4:0] rs,
                       input logic [4:0] rt);
    id_valid = 1'b1; id_rs = rs; id_rt = rt; id_rd = rd;
    id_uses_rs = 1'b1; id_uses_rt = 1'b1; id_regdst = 1'b1;
    id_regwrite = 1'b1; id_memread = 1'b0;
  endtask

  // lw rt, 0(rs)
  task automatic lw(input logic [4:0] rt, input logic [4:0] rs);
    id_valid = 1'b1; id_rs = rs; id_rt = rt; id_rd = 5'd0;
    id_uses_rs = 1'b1; id_uses_rt = 1'b0; id_regdst = 1'b0;
    id_regwrite = 1'b1; id_memread = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CNT_W-1:0] sat_cnt;
    nop_id();
    flush = 1'b0; mem_busy = 1'b0; reset = 1'b1;
    tick(); tick();
    reset = 1'b0;

    // add $3,$1,$2 ; sub $4,$3,$5 : MEM forwarding, no stall
    alu_r(5'd3, 5'd1, 5'd2); chk("reset_state", 8'h00, 0); tick();
    alu_r(5'd4, 5'd3, 5'd5); chk("t1_producer_ex", F_ALU, 0); tick();
    nop_id();                chk("t1_mem_fwd", F_MRS | F_ALU, 0); tick();
                             chk("t1_bubble_ex", 8'h00, 0); tick();

    // add $3 ; nop ; or $6,$7,$3 : WB forwarding on rt
    alu_r(5'd3, 5'd1, 5'd2); chk("t2_idle", 8'h00, 0); tick();
    nop_id();                chk("t2_producer_ex", F_ALU, 0); tick();
    alu_r(5'd6, 5'd7, 5'd3); chk("t2_gap", 8'h00, 0); tick();
    nop_id();                chk("t2_wb_fwd", F_WRT | F_ALU, 0); tick();
                             chk("t2_drain", 8'h00, 0); tick();

    // lw $8,0($1) ; add $9,$8,$8 : one stall then WB forwarding
    lw(5'd8, 5'd1);          chk("t3_idle", 8'h00, 0); tick();
    alu_r(5'd9, 5'd8, 5'd8); chk("t3_stall", F_ALU | F_STALL, 0); tick();
                             chk("t3_after_stall", 8'h00, 1); tick();
    nop_id();                chk("t3_wb_fwd", F_WRS | F_WRT | F_ALU, 1); tick();

    // write $0 then read $0 from EX with the writer in MEM and in WB
    alu_r(5'd0, 5'd1, 5'd2); chk("t4_idle", 8'h00, 1); tick();
    alu_r(5'd5, 5'd0, 5'd0); chk("t4_zero_ex", F_ALU, 1); tick();
    alu_r(5'd6, 5'd0, 5'd0); chk("t4_zero_mem", F_ALU, 1); tick();
    nop_id();                chk("t4_zero_wb", F_ALU, 1); tick();
                             chk("t4_drain", 8'h00, 1); tick();

    // load-use hazard coinciding with flush
    lw(5'd10, 5'd2);         chk("t5_idle", 8'h00, 1); tick();
    alu_r(5'd11, 5'd10, 5'd0); flush = 1'b1;
                             chk("t5_flush_hz", F_ALU, 1); tick();
    flush = 1'b0; nop_id();  chk("t5_count_kept", 8'h00, 1); tick();

    // freeze across a window with MEM (rt) and WB (rs) forwarding
    alu_r(5'd12, 5'd1, 5'd2);  chk("t6_idle", 8'h00, 1); tick();
    alu_r(5'd14, 5'd1, 5'd2);  chk("t6_p1_ex", F_ALU, 1); tick();
    alu_r(5'd15, 5'd12, 5'd14); chk("t6_p2_ex", F_ALU, 1); tick();
    nop_id(); mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("t6_busy_hold", F_MRT | F_WRS | F_ALU | F_HOLD, 1); tick();
    end
    mem_busy = 1'b0;
    chk("t6_freeze_exit", F_MRT | F_WRS | F_ALU | F_HOLD, 1); tick();
    alu_r(5'd16, 5'd15, 5'd15); chk("t6_resume", F_MRT | F_WRS | F_ALU, 1); tick();

    // reset asserted during a load-use stall
    lw(5'd17, 5'd1);           chk("t7_both_mem_fwd", F_MRS | F_MRT | F_ALU, 1); tick();
    alu_r(5'd18, 5'd17, 5'd0); reset = 1'b1;
                               chk("t7_stall_at_reset", F_ALU | F_STALL, 1); tick();
    reset = 1'b0;              chk("t7_after_reset", 8'h00, 0); tick();

    // stall counter saturation
    sat_cnt = '0;
    for (int i = 0; i < 5; i++) begin
      lw(5'd20, 5'd1); tick();
      alu_r(5'd21, 5'd20, 5'd0); chk("t8_sat_stall", F_ALU | F_STALL, sat_cnt); tick();
      tick();
      if (sat_cnt != '1) sat_cnt = sat_cnt + 1'b1;
    end
    nop_id(); chk("t8_saturated", F_WRS | F_ALU, 2'd3); tick();

    // reset while frozen returns to RUN
    mem_busy = 1'b1;           chk("t9_busy", F_HOLD, 2'd3); tick();
    reset = 1'b1;              chk("t9_frozen_at_reset", F_HOLD, 2'd3); tick();
    reset = 1'b0; mem_busy = 1'b0;
                               chk("t9_after_reset", 8'h00, 0); tick();

    tick(); tick();
    done = 1'b1;
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL %s: never sampled, required flags=%b cnt=%0d", e.name, e.flags, e.cnt);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
